// File: rtl/cache_line_fill_ctrl_pkg.sv
// Shared fill-state type and default sizing for the cache line fill controller.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_TAG  = 2'd2,
    ST_DONE = 2'd3
  } fill_state_t;

  localparam int DEF_ADDR_W         = 16;
  localparam int DEF_DATA_W         = 16;
  localparam int DEF_WORDS_PER_LINE = 8;

endpackage

// File: rtl/cache_line_fill_ctrl_if.sv
// Miss, memory-return and array-write signals of the line fill controller.
// The master side is the controller, the slave side is cache/memory.
interface cache_line_fill_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
);
  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;

  logic              fsm_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  write_word_idx;
  logic [DATA_W-1:0] write_data;
  logic              write_tag_array;
  logic              fill_done;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, mem_req, memory_address, write_data_array,
           write_word_idx, write_data, write_tag_array, fill_done
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, mem_req, memory_address, write_data_array,
           write_word_idx, write_data, write_tag_array, fill_done
  );

endinterface

// File: rtl/cache_line_fill_ctrl_counter.sv
// Word-slot index (wraps modulo the line) and received-word count for one fill.
module fill_word_counter
  import cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last_word
);

  logic [IDX_W:0] count;

  // Index width is exactly log2 of the line, so the increment wraps for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      count <= '0;
    end else if (load) begin
      idx   <= load_idx;
      count <= '0;
    end else if (inc) begin
      idx   <= idx + 1'b1;
      count <= count + 1'b1;
    end
  end

  assign last_word = (count == (IDX_W+1)'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Cache line fill controller: fetches one line word by word, then writes the tag.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start at the missing word and wrap.
module cache_line_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input logic                    clk,
  input logic                    rst,
  cache_line_fill_ctrl_if.master bus
);
  // state | meaning
  // IDLE  | waiting for a miss
  // FILL  | requesting words and writing them into the data array
  // TAG   | one-cycle tag-array write
  // DONE  | one-cycle completion pulse

  localparam int WORD_BYTES = DATA_W / 8;
  localparam int BYTE_SH    = $clog2(WORD_BYTES);
  localparam int IDX_W      = $clog2(WORDS_PER_LINE);
  localparam int OFF_W      = IDX_W + BYTE_SH;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << OFF_W) - 1);

  fill_state_t       state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  start_idx;
  logic              last_word;
  logic              accept;
  logic              load;
  logic              busy_q, req_q, tag_q, done_q;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign start_idx = bus.miss_address[OFF_W-1:BYTE_SH];
`else
  logic unused_offset;
  assign start_idx     = '0;
  assign unused_offset = ^bus.miss_address[OFF_W-1:0];
`endif

  assign load   = (state == ST_IDLE) && bus.miss_detected;
  assign accept = (state == ST_FILL) && bus.memory_data_valid;

  fill_word_counter #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_idx  (start_idx),
    .inc       (accept),
    .idx       (cur_idx),
    .last_word (last_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      base   <= '0;
      busy_q <= 1'b0;
      req_q  <= 1'b0;
      tag_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.miss_detected) begin
            base   <= bus.miss_address & ~LINE_MASK;
            state  <= ST_FILL;
            busy_q <= 1'b1;
            req_q  <= 1'b1;
          end
        end
        ST_FILL: begin
          // A dropped miss wins over completion: no tag write for an abandoned line.
          if (!bus.miss_detected) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            req_q  <= 1'b0;
          end else if (accept && last_word) begin
            state <= ST_TAG;
            req_q <= 1'b0;
            tag_q <= 1'b1;
          end
        end
        ST_TAG: begin
          state  <= ST_DONE;
          tag_q  <= 1'b0;
          done_q <= 1'b1;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          req_q  <= 1'b0;
          tag_q  <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Base has zero offset bits, so OR-ing the word offset can never carry into the tag.
  assign word_addr = base | (ADDR_W'(cur_idx) << BYTE_SH);

  assign bus.fsm_busy         = busy_q;
  assign bus.mem_req          = req_q;
  assign bus.memory_address   = req_q ? word_addr : '0;
  assign bus.write_data_array = accept;
  assign bus.write_word_idx   = accept ? cur_idx : '0;
  assign bus.write_data       = accept ? bus.memory_data : '0;
  assign bus.write_tag_array  = tag_q;
  assign bus.fill_done        = done_q;

endmodule
